// File: rtl/nn_stream_decoder.sv
// Windowed stochastic-to-binary readout: discards SETTLE cycles of the node's stream,
// then counts signed ones over 2^WIDTH cycles and reports unsigned count and bipolar value.
module nn_stream_decoder #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 16
) (
  input  logic                    CLK,
  input  logic                    INIT,
  input  logic                    start,
  input  logic                    IN,
  input  logic                    SIGN_IN,
  output logic                    busy,
  output logic                    valid,
  output logic [WIDTH:0]          count,
  output logic signed [WIDTH+1:0] value
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int CW = (WIDTH > SW) ? WIDTH : SW;
  localparam logic [CW-1:0] ACC_LAST = CW'((1 << WIDTH) - 1);
  localparam logic [CW-1:0] SET_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACC, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CW-1:0]             r_cnt;
  logic [WIDTH:0]            r_pos;
  logic [WIDTH:0]            r_neg;
  logic [WIDTH:0]            r_count;
  logic signed [WIDTH+1:0]   r_value;
  logic                      r_valid;

  logic                      w_set_last;
  logic                      w_acc_last;
  logic                      w_pinc;
  logic                      w_ninc;
  logic [WIDTH:0]            w_pos_fin;
  logic [WIDTH:0]            w_neg_fin;

  function automatic logic signed [WIDTH+1:0] bipolar(input logic [WIDTH:0] p,
                                                      input logic [WIDTH:0] n);
    return $signed({1'b0, p}) - $signed({1'b0, n});
  endfunction

  assign w_set_last = (r_cnt == SET_LAST);
  assign w_acc_last = (r_cnt == ACC_LAST);
  assign w_pinc     = IN & ~SIGN_IN;
  assign w_ninc     = IN & SIGN_IN;
  // Totals including the current sample, so the last window cycle lands in the result.
  assign w_pos_fin  = r_pos + (WIDTH+1)'(w_pinc);
  assign w_neg_fin  = r_neg + (WIDTH+1)'(w_ninc);

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = (SETTLE == 0) ? S_ACC : S_SETTLE;
      S_SETTLE: if (w_set_last) w_next = S_ACC;
      S_ACC:    if (w_acc_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      r_cnt   <= '0;
      r_pos   <= '0;
      r_neg   <= '0;
      r_count <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_pos <= '0;
            r_neg <= '0;
          end
        end
        S_SETTLE: r_cnt <= w_set_last ? '0 : r_cnt + CW'(1);
        S_ACC: begin
          r_pos <= w_pos_fin;
          r_neg <= w_neg_fin;
          r_cnt <= r_cnt + CW'(1);
          // Results land on the edge entering DONE so valid and data appear together.
          if (w_acc_last) begin
            r_count <= w_pos_fin + w_neg_fin;
            r_value <= bipolar(w_pos_fin, w_neg_fin);
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign valid = r_valid;
  assign count = r_count;
  assign value = r_value;

endmodule

// File: tb/tb_nn_stream_decoder.sv
// Bench for nn_stream_decoder: table vectors, randomized runs against a counting model,
// plus abort-by-INIT and SETTLE=0 sequences on a second instance.
module tb_nn_stream_decoder;

  logic CLK = 1'b0;
  logic INIT = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic IN = 1'b0, SIGN_IN = 1'b0;

  logic              busy_a, valid_a, busy_b, valid_b;
  logic [4:0]        count_a;
  logic signed [5:0] value_a;
  logic [3:0]        count_b;
  logic signed [4:0] value_b;

  int checks = 0;
  int errors = 0;
  int prev_c [2];
  int prev_v [2];

  always #5 CLK = ~CLK;

  nn_stream_decoder #(.WIDTH(4), .SETTLE(2)) u_a (
    .CLK(CLK), .INIT(INIT), .start(start_a), .IN(IN), .SIGN_IN(SIGN_IN),
    .busy(busy_a), .valid(valid_a), .count(count_a), .value(value_a));

  nn_stream_decoder #(.WIDTH(3), .SETTLE(0)) u_b (
    .CLK(CLK), .INIT(INIT), .start(start_b), .IN(IN), .SIGN_IN(SIGN_IN),
    .busy(busy_b), .valid(valid_b), .count(count_b), .value(value_b));

  typedef struct {
    bit          settle_in;
    logic [15:0] inv;
    logic [15:0] sgv;
    bit          extra;
    int          exp_c;
    int          exp_v;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: ones in the window, and positive ones minus negative ones.
  function automatic int m_count(input logic [15:0] inv, input int w);
    int c = 0;
    for (int i = 0; i < (1 << w); i++) c += int'(inv[i]);
    return c;
  endfunction

  function automatic int m_value(input logic [15:0] inv, input logic [15:0] sgv, input int w);
    int v = 0;
    for (int i = 0; i < (1 << w); i++) if (inv[i]) v += sgv[i] ? -1 : 1;
    return v;
  endfunction

  function automatic int obs_busy(input bit sel);
    return sel ? int'(busy_b) : int'(busy_a);
  endfunction
  function automatic int obs_valid(input bit sel);
    return sel ? int'(valid_b) : int'(valid_a);
  endfunction
  function automatic int obs_count(input bit sel);
    return sel ? int'(count_b) : int'(count_a);
  endfunction
  function automatic int obs_value(input bit sel);
    int v;
    if (sel) v = int'(value_b);
    else     v = int'(value_a);
    return v;
  endfunction

  // One measurement. Edge e counts posedges after the start edge; what is seen just
  // after edge e belongs to cycle t+e+1, so valid is expected at cycle SETTLE+2^W+1.
  task automatic run_meas(input bit sel, input bit settle_in, input logic [15:0] inv,
                          input logic [15:0] sgv, input bit extra,
                          input int exp_c, input int exp_v, input string tag);
    int s, w, lat, nvalid, vcyc, vc, vv, busy_bad, hold_bad;
    s = sel ? 0 : 2;
    w = sel ? 3 : 4;
    lat = s + (1 << w) + 1;
    nvalid = 0; vcyc = -1; vc = -999; vv = -999; busy_bad = 0; hold_bad = 0;
    @(negedge CLK);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    IN = 1'b0;
    @(posedge CLK);
    #1;
    if (obs_busy(sel) != 1) busy_bad++;
    if (obs_count(sel) != prev_c[sel] || obs_value(sel) != prev_v[sel]) hold_bad++;
    for (int e = 1; e <= lat; e++) begin
      @(negedge CLK);
      if (sel) start_b = (extra && e < lat) ? 1'($urandom) : 1'b0;
      else     start_a = (extra && e < lat) ? 1'($urandom) : 1'b0;
      SIGN_IN = 1'($urandom);
      if (e <= s) IN = settle_in;
      else if (e <= s + (1 << w)) begin
        IN      = inv[e-s-1];
        SIGN_IN = sgv[e-s-1];
      end else IN = 1'($urandom);
      @(posedge CLK);
      #1;
      if (obs_busy(sel) != ((e <= lat - 1) ? 1 : 0)) busy_bad++;
      if (obs_valid(sel) == 1) begin
        nvalid++;
        vcyc = e + 1;
        vc = obs_count(sel);
        vv = obs_value(sel);
      end else if (nvalid == 0) begin
        if (obs_count(sel) != prev_c[sel] || obs_value(sel) != prev_v[sel]) hold_bad++;
      end
    end
    chk({tag, " valid_cycle"}, vcyc, lat);
    chk({tag, " valid_pulses"}, nvalid, 1);
    chk({tag, " count"}, vc, exp_c);
    chk({tag, " value"}, vv, exp_v);
    chk({tag, " busy_profile_errs"}, busy_bad, 0);
    chk({tag, " hold_errs"}, hold_bad, 0);
    prev_c[sel] = exp_c;
    prev_v[sel] = exp_v;
  endtask

  initial begin
    logic [15:0] rin, rsg;
    int nv;
    prev_c[0] = 0; prev_v[0] = 0; prev_c[1] = 0; prev_v[1] = 0;

    //            settle inv       sgv       extra count value
    tbl[0] = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 16,  16};
    tbl[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16, -16};
    tbl[2] = '{1'b0, 16'h5555, 16'hFAFA, 1'b0,  8,   0};
    tbl[3] = '{1'b1, 16'h0000, 16'hFFFF, 1'b0,  0,   0};
    tbl[4] = '{1'b0, 16'h00FF, 16'h0003, 1'b1,  8,   4};
    tbl[5] = '{1'b0, 16'h8001, 16'h0000, 1'b1,  2,   2};
    tbl[6] = '{1'b1, 16'h0001, 16'h0000, 1'b0,  1,   1};
    tbl[7] = '{1'b0, 16'h8000, 16'h8000, 1'b1,  1,  -1};

    repeat (3) @(posedge CLK);
    #1;
    chk("reset busy", int'(busy_a), 0);
    chk("reset valid", int'(valid_a), 0);
    chk("reset count", int'(count_a), 0);
    chk("reset value", int'(value_a), 0);
    @(negedge CLK);
    INIT = 1'b0;
    repeat (2) @(posedge CLK);

    // Consecutive entries are back-to-back: each start lands in the cycle after DONE.
    for (int i = 0; i < 8; i++)
      run_meas(1'b0, tbl[i].settle_in, tbl[i].inv, tbl[i].sgv, tbl[i].extra,
               tbl[i].exp_c, tbl[i].exp_v, $sformatf("tbl%0d", i));

    // Abort mid-ACC: INIT between edges must clear outputs immediately.
    @(negedge CLK);
    start_a = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start_a = 1'b0;
    IN = 1'b1; SIGN_IN = 1'b0;
    repeat (8) @(posedge CLK);
    #3;
    chk("abort pre busy", int'(busy_a), 1);
    INIT = 1'b1;
    #1;
    chk("abort busy", int'(busy_a), 0);
    chk("abort valid", int'(valid_a), 0);
    chk("abort count", int'(count_a), 0);
    chk("abort value", int'(value_a), 0);
    @(negedge CLK);
    INIT = 1'b0;
    prev_c[0] = 0; prev_v[0] = 0; prev_c[1] = 0; prev_v[1] = 0;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      if (valid_a) nv++;
    end
    chk("abort no_valid", nv, 0);

    run_meas(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16, 16, "fresh");

    for (int r = 0; r < 20; r++) begin
      rin = 16'($urandom);
      rsg = 16'($urandom);
      run_meas(1'b0, 1'($urandom), rin, rsg, 1'($urandom),
               m_count(rin, 4), m_value(rin, rsg, 4), $sformatf("rnd%0d", r));
    end

    run_meas(1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 8, 8, "s0_ones");
    run_meas(1'b1, 1'b0, 16'h00FF, 16'h00FF, 1'b1, 8, -8, "s0_neg");
    for (int r = 0; r < 4; r++) begin
      rin = 16'($urandom);
      rsg = 16'($urandom);
      run_meas(1'b1, 1'b0, rin, rsg, 1'($urandom),
               m_count(rin, 3), m_value(rin, rsg, 3), $sformatf("s0_rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
